// File: rtl/riscv_regfile_pkg.sv
// ---------------------------------------------------------------------------
// riscv_regfile_pkg
//   Shared constants and helpers for the RV32I integer register file.
//   Also provides the core-wide `XLEN default when no defines file has
//   already set it.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package riscv_regfile_pkg;

    // Largest architectural register count addressable by a 5-bit field.
    localparam int unsigned NREG_MAX = 32;

    // Address width for a register count. Never narrower than one bit, so a
    // degenerate count still yields a legal port.
    function automatic int unsigned addr_width(input int unsigned nreg);
        return (nreg <= 1) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/riscv_register.sv
// ---------------------------------------------------------------------------
// riscv_register
//   Single enabled register with asynchronous active-low reset to a
//   per-instance init value. One instance backs each writable entry of
//   riscv_regfile.
//
// Ports
//   i_clk   in   1      clock, rising edge
//   i_rstn  in   1      asynchronous active-low reset
//   i_en    in   1      load enable
//   i_d     in   WIDTH  load data
//   o_q     out  WIDTH  stored value
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module riscv_register
    import riscv_regfile_pkg::*;
#(
    parameter int unsigned      WIDTH         = `XLEN,
    parameter logic [WIDTH-1:0] REGISTER_INIT = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // NOTE: defaulting data_d to the held value first means every path
    // assigns it, so no latch is inferred when i_en is low.
    always_comb begin
        data_d = data_q;
        if (i_en) begin
            data_d = i_d;
        end
    end

    // NOTE: the register array is built from individually reset flops
    // rather than a RAM macro, because every entry must show REGISTER_INIT
    // the moment reset asserts. State updates use non-blocking assignment
    // so all entries sample their inputs before any of them changes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q <= REGISTER_INIT;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/riscv_regfile.sv
// ---------------------------------------------------------------------------
// riscv_regfile
//   RV32I integer register file: NREG entries of XLEN bits, two
//   combinational read ports and one synchronous write port. Entry 0 is
//   hardwired to zero; entries 1..NREG-1 reset to REGISTER_INIT. With
//   BYPASS=1 a read of the address being written returns the write data in
//   the same cycle.
//
// Ports
//   i_clk       in   1       clock, rising edge
//   i_rstn      in   1       asynchronous active-low reset
//   i_rd_wen    in   1       write enable
//   i_rd_addr   in   AWIDTH  write address
//   i_rd_data   in   XLEN    write data
//   i_rs1_addr  in   AWIDTH  read port 1 address
//   o_rs1_data  out  XLEN    read port 1 data (combinational)
//   i_rs2_addr  in   AWIDTH  read port 2 address
//   o_rs2_data  out  XLEN    read port 2 data (combinational)
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile
    import riscv_regfile_pkg::*;
#(
    parameter int unsigned     XLEN          = `XLEN,
    parameter int unsigned     NREG          = 32,
    parameter int unsigned     AWIDTH        = addr_width(NREG),
    parameter logic [XLEN-1:0] REGISTER_INIT = '0,
    parameter int unsigned     BYPASS        = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_rd_wen,
    input  logic [AWIDTH-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_rd_data,
    input  logic [AWIDTH-1:0] i_rs1_addr,
    output logic [XLEN-1:0]   o_rs1_data,
    input  logic [AWIDTH-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs2_data
);

    // Never build more entries than a 5-bit register field can name.
    localparam int unsigned NENT = (NREG > NREG_MAX) ? NREG_MAX : NREG;

    logic [XLEN-1:0] entry [NENT];
    logic [NENT-1:0] wr_sel;
    logic            wr_hit;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // x0 is a constant with no storage and can never be selected for write.
    assign entry[0]  = '0;
    assign wr_sel[0] = 1'b0;

    // One-hot write decode. An out-of-range address matches no k, so the
    // write is dropped without extra logic; gating with i_rstn keeps a write
    // that overlaps reset from reaching any entry.
    for (genvar k = 1; k < NENT; k++) begin : g_entry
        assign wr_sel[k] = i_rd_wen & (i_rd_addr == AWIDTH'(k)) & i_rstn;

        riscv_register #(
            .WIDTH         (XLEN),
            .REGISTER_INIT (REGISTER_INIT)
        ) u_reg (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .i_en   (wr_sel[k]),
            .i_d    (i_rd_data),
            .o_q    (entry[k])
        );
    end

    // A write that will actually land this cycle: enabled, out of reset,
    // nonzero and in range. Bypass is only allowed for such writes.
    assign wr_hit = |wr_sel;

    // Read muxes. Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int k = 1; k < int'(NENT); k++) begin
            if (i_rs1_addr == AWIDTH'(k)) rs1_data = entry[k];
            if (i_rs2_addr == AWIDTH'(k)) rs2_data = entry[k];
        end
        if (BYPASS != 0 && wr_hit) begin
            if (i_rs1_addr == i_rd_addr) rs1_data = i_rd_data;
            if (i_rs2_addr == i_rd_addr) rs2_data = i_rd_data;
        end
    end

    assign o_rs1_data = rs1_data;
    assign o_rs2_data = rs2_data;

endmodule

// File: tb/tb_riscv_regfile.sv
// ---------------------------------------------------------------------------
// tb_riscv_regfile
//   Directed bench for riscv_regfile. Three instances share one stimulus:
//     u_a : NREG=32, BYPASS=1
//     u_b : NREG=32, BYPASS=0
//     u_c : NREG=20, AWIDTH=5, BYPASS=1
//   Inputs change 1 ns after a rising edge; outputs are compared before the
//   next rising edge.
// ---------------------------------------------------------------------------
module tb_riscv_regfile;

    localparam logic [31:0] INIT = 32'h0A0A0A0A;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wen;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] a1, a2, b1, b2, c1, c2;

    logic [31:0] m32 [32];
    logic [31:0] m20 [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_regfile #(.XLEN(32), .NREG(32), .AWIDTH(5), .REGISTER_INIT(INIT), .BYPASS(1)) u_a (
        .i_clk(clk), .i_rstn(rstn), .i_rd_wen(wen), .i_rd_addr(rd_addr), .i_rd_data(wdata),
        .i_rs1_addr(rs1), .o_rs1_data(a1), .i_rs2_addr(rs2), .o_rs2_data(a2));

    riscv_regfile #(.XLEN(32), .NREG(32), .AWIDTH(5), .REGISTER_INIT(INIT), .BYPASS(0)) u_b (
        .i_clk(clk), .i_rstn(rstn), .i_rd_wen(wen), .i_rd_addr(rd_addr), .i_rd_data(wdata),
        .i_rs1_addr(rs1), .o_rs1_data(b1), .i_rs2_addr(rs2), .o_rs2_data(b2));

    riscv_regfile #(.XLEN(32), .NREG(20), .AWIDTH(5), .REGISTER_INIT(INIT), .BYPASS(1)) u_c (
        .i_clk(clk), .i_rstn(rstn), .i_rd_wen(wen), .i_rd_addr(rd_addr), .i_rd_data(wdata),
        .i_rs1_addr(rs1), .o_rs1_data(c1), .i_rs2_addr(rs2), .o_rs2_data(c2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read: x0 and out-of-range read zero; a live, valid write to
    // the same address is visible when bypass is on; else the stored value.
    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input int nreg, input bit byp);
        if (ra == 5'd0 || int'(ra) >= nreg) return 32'h0;
        if (byp && rstn && wen && ra == rd_addr) return wdata;
        return (nreg == 20) ? m20[ra] : m32[ra];
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_a1"}, a1, exp_rd(rs1, 32, 1'b1));
        check({tag, "_a2"}, a2, exp_rd(rs2, 32, 1'b1));
        check({tag, "_b1"}, b1, exp_rd(rs1, 32, 1'b0));
        check({tag, "_b2"}, b2, exp_rd(rs2, 32, 1'b0));
        check({tag, "_c1"}, c1, exp_rd(rs1, 20, 1'b1));
        check({tag, "_c2"}, c2, exp_rd(rs2, 20, 1'b1));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m32[i] = (i == 0) ? 32'h0 : INIT;
            m20[i] = (i == 0) ? 32'h0 : INIT;
        end
    endtask

    // Commit the pending write to the models, then cross the rising edge.
    task automatic tick();
        if (rstn && wen && rd_addr != 5'd0) begin
            m32[rd_addr] = wdata;
            if (rd_addr < 5'd20) m20[rd_addr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for four cycles.
        rstn = 1'b0; wen = 1'b0; rd_addr = '0; wdata = '0; rs1 = '0; rs2 = '0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        check("rst_x0_a", a1, 32'h0);
        rs1 = 5'd1; rs2 = 5'd31; #1;
        check("rst_x1_a", a1, INIT);
        check("rst_x31_b", b2, INIT);
        check("rst_x31_c_oor", c2, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i); #1;
            check_all("rst_sweep");
        end
        rstn = 1'b1;
        @(posedge clk); #1;

        // Plain write then read.
        wen = 1'b1; rd_addr = 5'd5; wdata = 32'hDEADBEEF; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        wen = 1'b0; rs1 = 5'd5; rs2 = 5'd0; #1;
        check("x5_a1", a1, 32'hDEADBEEF);
        check("x5_a2", a2, 32'h0);
        check("x5_b1", b1, 32'hDEADBEEF);
        check_all("x5");

        // Write to x0 is discarded, including on the bypass path.
        wen = 1'b1; rd_addr = 5'd0; wdata = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0; #1;
        check("x0_byp_a1", a1, 32'h0);
        tick();
        wen = 1'b0; #1;
        check("x0_a1", a1, 32'h0);
        check("x0_b1", b1, 32'h0);

        // Same-cycle write and read of x7: bypass vs stored value.
        wen = 1'b1; rd_addr = 5'd7; wdata = 32'h12345678; rs1 = 5'd7; rs2 = 5'd7; #1;
        check("x7_byp_a1", a1, 32'h12345678);
        check("x7_byp_a2", a2, 32'h12345678);
        check("x7_nobyp_b1", b1, INIT);
        check("x7_nobyp_b2", b2, INIT);
        check("x7_byp_c1", c1, 32'h12345678);
        tick();
        wen = 1'b0; #1;
        check("x7_after_b1", b1, 32'h12345678);
        check("x7_after_b2", b2, 32'h12345678);

        // Out-of-range write on the NREG=20 instance.
        wen = 1'b1; rd_addr = 5'd25; wdata = 32'h55; rs1 = 5'd25; rs2 = 5'd19; #1;
        check("oor_byp_c1", c1, 32'h0);
        check("oor_c2", c2, INIT);
        check("inr_byp_a1", a1, 32'h55);
        tick();
        wen = 1'b0; #1;
        check("oor_after_c1", c1, 32'h0);
        check("oor_after_c2", c2, INIT);
        check("inr_after_a1", a1, 32'h55);
        check_all("oor");

        // Reset asserted while a write to x9 is pending.
        wen = 1'b1; rd_addr = 5'd9; wdata = 32'hCAFE; rs1 = 5'd9; rs2 = 5'd9;
        tick();
        wdata = 32'hBEEF; #1;
        check("x9_byp_a1", a1, 32'hBEEF);
        check("x9_old_b1", b1, 32'hCAFE);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        check("x9_rst_a1", a1, INIT);
        check("x9_rst_b1", b1, INIT);
        check("x9_rst_c1", c1, INIT);
        tick();
        wen = 1'b0; rstn = 1'b1; #1;
        check("x9_rel_a1", a1, INIT);
        check("x9_rel_b2", b2, INIT);
        check("x9_rel_c2", c2, INIT);
        tick();
        check_all("x9_hold");

        // Random soak against the reference models.
        for (int i = 0; i < 100; i++) begin
            wen     = 1'($urandom_range(0, 1));
            rd_addr = 5'($urandom);
            wdata   = $urandom;
            rs1     = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            rs2     = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            #1;
            check_all("soak");
            tick();
        end
        wen = 1'b0; #1;
        check_all("soak_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
